// File: rtl/imm_gen_adder.sv
// imm_gen_adder: RV32I immediate generator and 32-bit adder.
// The decoded immediate, the sum and the flags are combinational for
// same-cycle use by the datapath. A registered copy of each is kept
// for pipelining and debug taps.
// There is no handshake: every clock edge with rst low captures fresh values.
module imm_gen_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  instr_type,
    input  logic [31:0] instr,
    input  logic [31:0] IN1,
    input  logic [31:0] IN2,
    output logic [31:0] imm,
    output logic [31:0] RESULT,
    output logic        carry,
    output logic        overflow,
    output logic        zero,
    output logic [31:0] imm_q,
    output logic [31:0] result_q,
    output logic [2:0]  flags_q
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [32:0] sum33;
    logic [31:0] imm_d;
    logic [31:0] result_d;
    logic [2:0]  flags_d;

    // Immediate decode. OP, unknown and X opcodes fall to the default arm and give 0.
    always_comb begin
        imm = 32'h0;
        case (instr_type)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
    end

    // Adder and flags. The sum wraps modulo 2^32, and bit 32 of the sum is the carry.
    always_comb begin
        sum33    = {1'b0, IN1} + {1'b0, IN2};
        RESULT   = sum33[31:0];
        carry    = sum33[32];
        overflow = (IN1[31] == IN2[31]) && (sum33[31] != IN1[31]);
        zero     = (sum33[31:0] == 32'h0);
    end

    // Next-state values for the debug/pipeline registers
    always_comb begin
        imm_d    = imm;
        result_d = RESULT;
        flags_d  = {carry, overflow, zero};
    end

    // Registered copies. A synchronous reset clears them; the combinational outputs stay live.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q    <= 32'h0;
            result_q <= 32'h0;
            flags_q  <= 3'b000;
        end else begin
            imm_q    <= imm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_adder.sv
// Directed bench for imm_gen_adder. Each step drives the inputs on the falling edge.
// It checks the combinational outputs shortly afterwards.
// It checks the registered outputs 1 ns after the next rising edge.
// Expected values go into queues when a step is driven and come out when it is checked.
module tb_imm_gen_adder;

    logic        clk;
    logic        rst;
    logic [6:0]  instr_type;
    logic [31:0] instr;
    logic [31:0] IN1;
    logic [31:0] IN2;
    logic [31:0] imm;
    logic [31:0] RESULT;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic [31:0] imm_q;
    logic [31:0] result_q;
    logic [2:0]  flags_q;

    // Packed expectation: {imm[31:0], result[31:0], flags[2:0]}
    logic [66:0] comb_q[$];
    logic [66:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    imm_gen_adder dut (
        .clk        (clk),
        .rst        (rst),
        .instr_type (instr_type),
        .instr      (instr),
        .IN1        (IN1),
        .IN2        (IN2),
        .imm        (imm),
        .RESULT     (RESULT),
        .carry      (carry),
        .overflow   (overflow),
        .zero       (zero),
        .imm_q      (imm_q),
        .result_q   (result_q),
        .flags_q    (flags_q)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Flags model from the definition: {carry, overflow, zero}
    function automatic logic [2:0] model_flags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        return {s[32], ov, (s[31:0] == 32'h0)};
    endfunction

    // One directed step: drive the inputs, check the combinational outputs, then the registered ones.
    task automatic step(input string tag, input logic r, input logic [6:0] t,
                        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_imm, input logic [31:0] e_res,
                        input logic [2:0] e_fl);
        logic [66:0] e;
        @(negedge clk);
        rst        = r;
        instr_type = t;
        instr      = ins;
        IN1        = a;
        IN2        = b;
        comb_q.push_back({e_imm, e_res, e_fl});
        exp_q.push_back(r ? 67'h0 : {e_imm, e_res, e_fl});
        #1;
        e = comb_q.pop_front();
        chk32({tag, ".imm"}, imm, e[66:35]);
        chk32({tag, ".RESULT"}, RESULT, e[34:3]);
        chk3({tag, ".flags"}, {carry, overflow, zero}, e[2:0]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk32({tag, ".imm_q"}, imm_q, e[66:35]);
        chk32({tag, ".result_q"}, result_q, e[34:3]);
        chk3({tag, ".flags_q"}, flags_q, e[2:0]);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        instr_type = 7'b0;
        instr      = 32'h0;
        IN1        = 32'h0;
        IN2        = 32'h0;

        // Reset held for two edges; the immediates still decode combinationally
        step("rst0_itype_neg", 1'b1, 7'b0010011, 32'hFFF00093, 32'h0, 32'h0,
             32'hFFFFFFFF, 32'h0, 3'b001);
        step("rst1_itype_pos", 1'b1, 7'b0010011, 32'h7FF00093, 32'h0, 32'h0,
             32'h000007FF, 32'h0, 3'b001);
        // Release: first capture, 3 + 4 = 7, R-type imm is 0
        step("rel_rtype_add7", 1'b0, 7'b0110011, 32'h002081B3, 32'd3, 32'd4,
             32'h0, 32'd7, 3'b000);
        step("store_wrap", 1'b0, 7'b0100011, 32'hFE112E23, 32'hFFFFFFFF, 32'h1,
             32'hFFFFFFFC, 32'h0, 3'b101);
        step("branch_ovf", 1'b0, 7'b1100011, 32'hFE000CE3, 32'h7FFFFFFF, 32'h1,
             32'hFFFFFFF8, 32'h80000000, 3'b010);
        step("lui_sub", 1'b0, 7'b0110111, 32'h123450B7, 32'd5, 32'hFFFFFFFD,
             32'h12345000, 32'd2, 3'b100);
        // Reset mid-stream clears the registers on that edge
        step("mid_rst_jal", 1'b1, 7'b1101111, 32'h001000EF, 32'd3, 32'd4,
             32'h00000800, 32'd7, 3'b000);
        step("rel_auipc", 1'b0, 7'b0010111, 32'h123450B7, 32'd10, 32'd20,
             32'h12345000, 32'd30, 3'b000);
        step("unknown_op", 1'b0, 7'b1111111, 32'hFFFFFFFF, 32'h0, 32'h0,
             32'h0, 32'h0, 3'b001);
        step("load_itype", 1'b0, 7'b0000011, 32'hFFF00093, 32'h80000000, 32'h80000000,
             32'hFFFFFFFF, 32'h0, 3'b111);
        step("jalr_itype", 1'b0, 7'b1100111, 32'h7FF00093, 32'h1, 32'h2,
             32'h000007FF, 32'd3, 3'b000);

        // Random adder operands with a fixed R-type opcode
        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = $urandom();
            if (i == 0) b = 32'h0 - a;
            step($sformatf("rand_add%0d", i), 1'b0, 7'b0110011, 32'h002081B3, a, b,
                 32'h0, a + b, model_flags(a, b));
        end

        // Final registered check after reset with no outstanding expectation
        step("final_rst", 1'b1, 7'b0010011, 32'hFFF00093, 32'h1, 32'h1,
             32'hFFFFFFFF, 32'd2, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
